// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of one shared memory port
// Define ARB_STARVE_GUARD_EN to enable the fetch starvation guard (STARVE_MAX).
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRdata,
  output logic        IReady,
  input  logic        DReq,
  input  logic        DWe,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWdata,
  output logic [31:0] DRdata,
  output logic        DReady,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWdata,
  input  logic [31:0] MemRdata,
  input  logic        MemAck,
  output logic        StallF,
  output logic        StallM
);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  state_t      state_q;
  logic        mem_req_q, mem_we_q, iready_q, dready_q;
  logic [31:0] mem_addr_q, mem_wdata_q, irdata_q, drdata_q;
  logic        data_win;

  // The starve counter is 3 bits wide, so the threshold must fit in it.
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("mem_arbiter: STARVE_MAX must be in 1..7");
  end

`ifdef ARB_STARVE_GUARD_EN
  logic [2:0] starve_q;
  logic       starve_hit;
  assign starve_hit = (int'(starve_q) >= STARVE_MAX);
  assign data_win   = DReq & ~(IReq & starve_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q <= 3'd0;
    end else if (!IReq) begin
      starve_q <= 3'd0;
    end else if (state_q == IDLE) begin
      // With IReq held, an IDLE cycle is either a data grant or a fetch grant.
      starve_q <= data_win ? starve_q + 3'd1 : 3'd0;
    end
  end
`else
  assign data_win = DReq;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      irdata_q    <= 32'd0;
      drdata_q    <= 32'd0;
      iready_q    <= 1'b0;
      dready_q    <= 1'b0;
    end else begin
      iready_q <= 1'b0;
      dready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_win) begin
            state_q     <= DBUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= DWe;
            mem_addr_q  <= DAddr;
            mem_wdata_q <= DWdata;
          end else if (IReq) begin
            state_q     <= IBUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= IAddr;
            mem_wdata_q <= 32'd0;
          end
        end
        IBUSY, DBUSY: begin
          // Requester may have dropped its request; the transaction still completes.
          if (MemAck) begin
            state_q   <= RESP;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            if (state_q == IBUSY) begin
              irdata_q <= MemRdata;
              iready_q <= 1'b1;
            end else begin
              if (!mem_we_q) drdata_q <= MemRdata;
              dready_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MemReq   = mem_req_q;
  assign MemWe    = mem_we_q;
  assign MemAddr  = mem_addr_q;
  assign MemWdata = mem_wdata_q;
  assign IRdata   = irdata_q;
  assign DRdata   = drdata_q;
  assign IReady   = iready_q;
  assign DReady   = dready_q;
  assign StallF   = IReq & ~iready_q;
  assign StallM   = DReq & ~dready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed vector bench for mem_arbiter
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReq, DReq, DWe, MemAck;
  logic [31:0] IAddr, DAddr, DWdata, MemRdata;
  logic [31:0] IRdata, DRdata, MemAddr, MemWdata;
  logic        IReady, DReady, MemReq, MemWe, StallF, StallM;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRdata(IRdata), .IReady(IReady),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWdata(DWdata),
    .DRdata(DRdata), .DReady(DReady),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemRdata(MemRdata), .MemAck(MemAck),
    .StallF(StallF), .StallM(StallM)
  );

  typedef struct {
    logic        ireq;
    logic        dreq;
    logic        dwe;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] rdata;
    int          ack_dly;
    logic        exp_d;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_ir;
    logic [31:0] exp_dr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_memreq(output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (MemReq) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int   n;
    v = vecs[k];
    IReq = v.ireq; IAddr = v.iaddr;
    DReq = v.dreq; DWe = v.dwe; DAddr = v.daddr; DWdata = v.dwdata;
    wait_memreq(n);
    check($sformatf("v%0d_memreq_lat", k), n, 1);
    check($sformatf("v%0d_memwe", k), MemWe, v.exp_we);
    check($sformatf("v%0d_memaddr", k), MemAddr, v.exp_addr);
    check($sformatf("v%0d_memwdata", k), MemWdata, v.exp_wdata);
    check($sformatf("v%0d_stall", k), v.exp_d ? StallM : StallF, 1);
    repeat (v.ack_dly) @(negedge clk);
    check($sformatf("v%0d_memreq_held", k), MemReq, 1);
    MemAck = 1'b1; MemRdata = v.rdata;
    @(negedge clk);
    MemAck = 1'b0;
    check($sformatf("v%0d_iready", k), IReady, !v.exp_d);
    check($sformatf("v%0d_dready", k), DReady, v.exp_d);
    check($sformatf("v%0d_irdata", k), IRdata, v.exp_ir);
    check($sformatf("v%0d_drdata", k), DRdata, v.exp_dr);
    check($sformatf("v%0d_memreq_resp", k), MemReq, 0);
    check($sformatf("v%0d_stall_done", k), v.exp_d ? StallM : StallF, 0);
    if (v.exp_d) DReq = 1'b0; else IReq = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_ready_pulse", k), {IReady, DReady}, 2'b00);
  endtask

  initial begin
    int   n;
    logic exp_i;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 32'hE3A00005, 2,
                1'b0, 1'b0, 32'h100, 32'h0, 32'hE3A00005, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h200, 32'hCAFEF00D, 32'h99999999, 0,
                1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 32'hE3A00005, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 32'h104, 32'h0, 32'h0, 32'h11112222, 1,
                1'b0, 1'b0, 32'h104, 32'h0, 32'h11112222, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h300, 32'h0, 32'hDEADBEEF, 3,
                1'b1, 1'b0, 32'h300, 32'h0, 32'h11112222, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h304, 32'h12345678, 32'h55555555, 0,
                1'b1, 1'b1, 32'h304, 32'h12345678, 32'h11112222, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h0, 32'h0, 32'hA5A5A5A5, 0,
                1'b0, 1'b0, 32'h108, 32'h0, 32'hA5A5A5A5, 32'hDEADBEEF};

    reset = 1'b1; IReq = 0; DReq = 0; DWe = 0; MemAck = 0;
    IAddr = 0; DAddr = 0; DWdata = 0; MemRdata = 0;
    repeat (2) @(negedge clk);
    check("rst_memreq", MemReq, 0);
    check("rst_memwe", MemWe, 0);
    check("rst_memaddr", MemAddr, 0);
    check("rst_memwdata", MemWdata, 0);
    check("rst_ready", {IReady, DReady}, 2'b00);
    check("rst_irdata", IRdata, 0);
    check("rst_drdata", DRdata, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Stray MemAck while idle
    MemAck = 1'b1; MemRdata = 32'hFFFFFFFF;
    @(negedge clk);
    MemAck = 1'b0;
    check("idle_ack_ready", {IReady, DReady}, 2'b00);
    check("idle_ack_memreq", MemReq, 0);
    @(negedge clk);
    check("idle_ack_ready2", {IReady, DReady}, 2'b00);
    check("idle_ack_irdata", IRdata, 32'hA5A5A5A5);
    check("idle_ack_drdata", DRdata, 32'hDEADBEEF);

    // Data request dropped while DBUSY still completes
    DReq = 1'b1; DWe = 1'b0; DAddr = 32'h400;
    wait_memreq(n);
    check("flush_memreq", n, 1);
    DReq = 1'b0;
    @(negedge clk);
    check("flush_memreq_held", MemReq, 1);
    MemAck = 1'b1; MemRdata = 32'h0BADF00D;
    @(negedge clk);
    MemAck = 1'b0;
    check("flush_dready", DReady, 1);
    check("flush_drdata", DRdata, 32'h0BADF00D);
    @(negedge clk);
    check("flush_dready_once", DReady, 0);
    @(negedge clk);
    check("flush_no_regrant", MemReq, 0);

    // Reset in the middle of a data transaction
    DReq = 1'b1; DWe = 1'b1; DAddr = 32'h500; DWdata = 32'h77;
    wait_memreq(n);
    check("rstmid_memreq", n, 1);
    reset = 1'b1;
    #1;
    check("rstmid_memreq_drop", MemReq, 0);
    check("rstmid_memaddr", MemAddr, 0);
    check("rstmid_drdata", DRdata, 0);
    DReq = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_dready", DReady, 0);
    MemAck = 1'b1;
    @(negedge clk);
    MemAck = 1'b0;
    check("rstmid_stray_ack", {IReady, DReady}, 2'b00);
    @(negedge clk);
    check("rstmid_idle", {MemReq, IReady, DReady}, 3'b000);

    // Both requests held continuously: observe grant order
    IReq = 1'b1; IAddr = 32'h1000; DReq = 1'b1; DWe = 1'b0; DAddr = 32'h2000;
    for (int g = 0; g < 5; g++) begin
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (g == 4);
`else
      exp_i = 1'b0;
`endif
      wait_memreq(n);
      check($sformatf("starve_g%0d_seen", g), (n != 0), 1);
      check($sformatf("starve_g%0d_addr", g), MemAddr, exp_i ? 32'h1000 : 32'h2000);
      MemAck = 1'b1; MemRdata = 32'h100 + g;
      @(negedge clk);
      MemAck = 1'b0;
      check($sformatf("starve_g%0d_ready", g), {IReady, DReady}, exp_i ? 2'b10 : 2'b01);
      if (g == 4) begin
        IReq = 1'b0; DReq = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
    check("starve_end_idle", MemReq, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
